ppi_rx: RTL and testbench
=========================

# ppi_rx

Receiver and parser for the 16-bit PPI packet link: the stage directly downstream of the PPI packet generator. It samples `data_ppi` on rising edges of the strobe `clk_ppi` after a frame-sync pulse and locks onto the 0xFFFF start word. It stores the packet in a 256×16 buffer, checks the XOR checksum in the last word, and reports the command/sub-code to the DDS and time-diagram control logic. All inputs are synchronous to `clk`; `clk_ppi` runs at no more than `clk`/2.

## Interface
- `PKT_LEN`, 256: words per packet including start word and checksum; power of 2, ≤ 256.
- `TIMEOUT`, 64: `clk` cycles without a strobe edge before an in-progress frame is aborted.
- `START_WORD`, 16'hFFFF: start-of-packet code; also the checksum seed.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `fs` in 1: frame sync from the transmitter.
- `clk_ppi` in 1: word strobe; data is valid at its rising edge.
- `data_ppi` in 16: packet word.
- `rd_addr` in 8: buffer read address.
- `rd_data` out 16: buffer word at `rd_addr`; registered, 1-cycle latency.
- `pkt_cmd` out 16: word 1 of the last good packet (0xFFF0 time diagram, 0xFFF1 DDS).
- `pkt_sub` out 16: word 2 of the last good packet.
- `pkt_valid` out 1: one-cycle pulse; packet complete and checksum correct.
- `pkt_crc_err` out 1: one-cycle pulse; packet complete and checksum wrong.
- `pkt_abort` out 1: one-cycle pulse; frame abandoned on timeout or restart.
- `busy` out 1: high in HUNT, RECV and CHECK.
- `ts_day`, `ts_hour`, `ts_min`, `ts_sec`, `ts_ms`, `ts_us` out 16 each: words 3–8 of the last good packet. Present only with the configuration macro (see Configuration).

## Operation
- **Input stage.** `fs`, `clk_ppi` and `data_ppi` are registered once.
- **Sample.** A sample event occurs when the registered `clk_ppi` is 1 and its previous value was 0. The word taken is the registered `data_ppi` from the same cycle.
- **FS event.** An FS event is a registered 0→1 transition of `fs`.
- **IDLE.**
  - On an FS event: go to HUNT, clear the timeout counter.
  - Sample events are ignored.
- **HUNT.**
  - On a sample equal to `START_WORD`: write it to buf[0], set idx = 1, set crc = `START_WORD`, go to RECV.
  - Any other word is discarded.
- **RECV.**
  - On each sample with idx = 1 and word = `START_WORD`: preamble repeat. Discard the word; idx stays 1.
  - Otherwise, for idx 1..PKT_LEN−2: write buf[idx], set crc ^= word, set idx += 1.
  - At idx = PKT_LEN−1: write buf[idx], latch match = (word == crc), go to CHECK.
  - Checksum definition: `START_WORD` XOR word1 XOR … XOR word(PKT_LEN−2).
- **CHECK (one cycle).**
  - If match: pulse `pkt_valid`, update `pkt_cmd`/`pkt_sub` (and `ts_*` when configured) from buf words 1–8 held in shadow registers.
  - If no match: pulse `pkt_crc_err`; `pkt_cmd`/`pkt_sub`/`ts_*` keep their old values.
  - Go to IDLE.
- **Timeout.** The counter increments every cycle in HUNT/RECV and clears on each sample event. On reaching `TIMEOUT`: pulse `pkt_abort`, go to IDLE.
- **FS event in HUNT or RECV.** Restart in HUNT, clear idx and crc. Pulse `pkt_abort` if the state was RECV.
- **FS event in CHECK.** CHECK completes normally, then the state goes to HUNT instead of IDLE.
- **Simultaneous FS event and sample in HUNT/RECV.** FS wins; the sample is discarded.
- **Simultaneous FS event and timeout.** FS wins; no abort pulse.
- **Buffer lifetime.** Contents are valid from `pkt_valid` until the next FS event. Reads during RECV return partially overwritten data and are not forbidden.
- **Reset.**
  - State goes to IDLE; idx, crc and the timeout counter go to 0.
  - `pkt_valid`, `pkt_crc_err`, `pkt_abort`, `busy` go to 0; `pkt_cmd`, `pkt_sub`, `ts_*`, `rd_data` go to 0x0000.
  - Buffer contents are not cleared.
  - Reset mid-packet discards the frame silently, with no abort pulse.

## Timing
- A strobe rising edge first registered at clock edge k is processed (buffer write, crc update) at edge k+1.
- For the final word: CHECK occupies the cycle after edge k+1. `pkt_valid`/`pkt_crc_err` and the updated `pkt_cmd`/`pkt_sub` appear after edge k+2.
- An FS event registered at edge k: `busy` is high after edge k+1.
- `rd_data` reflects `rd_addr` one clock after it is presented. A write and a read to the same address in the same cycle return the old data.
- Minimum strobe period is 2 `clk` cycles, so back-to-back sample events never occur.

## Configuration
- `PPI_RX_TIMESTAMP_EN` defined: the six `ts_*` ports and their shadow registers exist. They update in CHECK on a good packet only.
- `PPI_RX_TIMESTAMP_EN` not defined: the `ts_*` ports and registers are absent. All other behaviour is identical.

## Test plan
- **Good DDS packet.** FS, then 0xFFFF, 0xFFF1, 0xFFD1, 0, 1, 1, 1, 1, 50, filler words 9..254 = index, correct checksum in word 255 → `pkt_valid` ×1; `pkt_cmd` = 0xFFF1; `pkt_sub` = 0xFFD1; `ts_us` = 50; `rd_addr` = 100 gives `rd_data` = 100.
- **Corrupt word.** Same packet with word 100 = 0x0000 → `pkt_crc_err` ×1, no `pkt_valid`; `pkt_cmd` keeps its prior value.
- **Preamble repeat.** Three 0xFFFF words before 0xFFF0 → buf[1] = 0xFFF0; packet accepted with a correct checksum.
- **Timeout.** Strobe stops after word 50 → `pkt_abort` exactly 64 cycles after the last sample; `busy` low next cycle.
- **Restart.** FS event during word 120 → `pkt_abort`; a following full packet is received with `pkt_valid`.
- **Reset.** `rst_n` = 0 for one cycle mid-packet → all outputs 0, no pulses; the next FS-framed packet passes.

Source files
------------

// File: rtl/ppi_rx.sv
// PPI packet receiver: frame-sync/start-word lock, 256x16 packet buffer, XOR checksum check.
// Define PPI_RX_TIMESTAMP_EN to add the ts_* timestamp outputs (words 3-8 of a good packet).
module ppi_rx #(
   parameter int unsigned PKT_LEN    = 256,
   parameter int unsigned TIMEOUT    = 64,
   parameter logic [15:0] START_WORD = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fs,
   input  logic        clk_ppi,
   input  logic [15:0] data_ppi,
   input  logic [7:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [15:0] pkt_cmd,
   output logic [15:0] pkt_sub,
   output logic        pkt_valid,
   output logic        pkt_crc_err,
   output logic        pkt_abort,
   output logic        busy
`ifdef PPI_RX_TIMESTAMP_EN
   ,
   output logic [15:0] ts_day,
   output logic [15:0] ts_hour,
   output logic [15:0] ts_min,
   output logic [15:0] ts_sec,
   output logic [15:0] ts_ms,
   output logic [15:0] ts_us
`endif
);

`ifdef PPI_RX_TIMESTAMP_EN
   localparam int unsigned SH_N = 8;
`else
   localparam int unsigned SH_N = 2;
`endif
   localparam int unsigned CW   = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  LAST = 8'(PKT_LEN - 1);

   typedef enum logic [1:0] {IDLE, HUNT, RECV, CHECK} state_t;

   state_t        state, state_next;
   logic          fs_r, fs_d, stb_r, stb_d;
   logic [15:0]   word;
   logic [7:0]    idx;
   logic [15:0]   crc;
   logic [CW-1:0] cnt;
   logic          match;
   logic [15:0]   mem [0:255];
   logic [15:0]   sh [1:SH_N];

   logic          fs_ev, sample, active, timeout;
   logic          wr_en, restart, abort_set, good, bad, last;
   logic [7:0]    wr_addr;

   assign fs_ev   = fs_r & ~fs_d;
   assign sample  = stb_r & ~stb_d;
   assign active  = (state == HUNT) || (state == RECV);
   // A sample in the terminal-count cycle clears the counter, so it beats the timeout.
   assign timeout = active && !sample && (cnt == CW'(TIMEOUT - 1));
   assign wr_addr = (state == HUNT) ? 8'd0 : idx;
   assign last    = (idx == LAST);
   assign busy    = (state != IDLE);

   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      restart    = 1'b0;
      abort_set  = 1'b0;
      good       = 1'b0;
      bad        = 1'b0;
      unique case (state)
         IDLE: begin
            if (fs_ev) state_next = HUNT;
         end
         HUNT: begin
            if (fs_ev) begin
               restart = 1'b1;
            end else if (timeout) begin
               abort_set  = 1'b1;
               state_next = IDLE;
            end else if (sample && word == START_WORD) begin
               wr_en      = 1'b1;
               state_next = RECV;
            end
         end
         RECV: begin
            // FS restarts the hunt; a coincident timeout is swallowed without an abort.
            if (fs_ev) begin
               restart    = 1'b1;
               abort_set  = !timeout;
               state_next = HUNT;
            end else if (timeout) begin
               abort_set  = 1'b1;
               state_next = IDLE;
            end else if (sample && !(idx == 8'd1 && word == START_WORD)) begin
               wr_en = 1'b1;
               if (last) state_next = CHECK;
            end
         end
         CHECK: begin
            good       = match;
            bad        = !match;
            state_next = fs_ev ? HUNT : IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem[wr_addr] <= word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         fs_r        <= 1'b0;
         fs_d        <= 1'b0;
         stb_r       <= 1'b0;
         stb_d       <= 1'b0;
         word        <= '0;
         idx         <= '0;
         crc         <= '0;
         cnt         <= '0;
         match       <= 1'b0;
         pkt_valid   <= 1'b0;
         pkt_crc_err <= 1'b0;
         pkt_abort   <= 1'b0;
         pkt_cmd     <= '0;
         pkt_sub     <= '0;
         rd_data     <= '0;
         for (int unsigned i = 1; i <= SH_N; i++) sh[i] <= '0;
`ifdef PPI_RX_TIMESTAMP_EN
         ts_day  <= '0;
         ts_hour <= '0;
         ts_min  <= '0;
         ts_sec  <= '0;
         ts_ms   <= '0;
         ts_us   <= '0;
`endif
      end else begin
         state       <= state_next;
         fs_r        <= fs;
         fs_d        <= fs_r;
         stb_r       <= clk_ppi;
         stb_d       <= stb_r;
         word        <= data_ppi;
         rd_data     <= mem[rd_addr];
         pkt_valid   <= good;
         pkt_crc_err <= bad;
         pkt_abort   <= abort_set;
         cnt         <= (active && !fs_ev && !sample) ? cnt + 1'b1 : '0;

         if (restart || state_next == IDLE) begin
            idx <= '0;
            crc <= '0;
         end else if (wr_en) begin
            if (state == HUNT) begin
               idx <= 8'd1;
               crc <= START_WORD;
            end else if (last) begin
               match <= (word == crc);
               idx   <= '0;
            end else begin
               crc <= crc ^ word;
               idx <= idx + 8'd1;
            end
         end

         for (int unsigned i = 1; i <= SH_N; i++)
            if (wr_en && wr_addr == 8'(i)) sh[i] <= word;

         if (good) begin
            pkt_cmd <= sh[1];
            pkt_sub <= sh[2];
`ifdef PPI_RX_TIMESTAMP_EN
            ts_day  <= sh[3];
            ts_hour <= sh[4];
            ts_min  <= sh[5];
            ts_sec  <= sh[6];
            ts_ms   <= sh[7];
            ts_us   <= sh[8];
`endif
         end
      end
   end

endmodule

// File: tb/tb_ppi_rx.sv
// Directed self-checking bench for ppi_rx: good, corrupt, preamble, timeout, restart, reset.
module tb_ppi_rx;
   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        fs       = 1'b0;
   logic        clk_ppi  = 1'b0;
   logic [15:0] data_ppi = '0;
   logic [7:0]  rd_addr  = '0;
   logic [15:0] rd_data, pkt_cmd, pkt_sub;
   logic        pkt_valid, pkt_crc_err, pkt_abort, busy;
`ifdef PPI_RX_TIMESTAMP_EN
   logic [15:0] ts_day, ts_hour, ts_min, ts_sec, ts_ms, ts_us;
`endif

   int unsigned n_chk = 0, n_err = 0;
   int unsigned n_valid = 0, n_crc = 0, n_abort = 0;
   logic [15:0] pkt [0:255];

   always #5 clk = ~clk;

   ppi_rx #(.PKT_LEN(256), .TIMEOUT(64), .START_WORD(16'hFFFF)) dut (
      .clk(clk), .rst_n(rst_n), .fs(fs), .clk_ppi(clk_ppi), .data_ppi(data_ppi),
      .rd_addr(rd_addr), .rd_data(rd_data), .pkt_cmd(pkt_cmd), .pkt_sub(pkt_sub),
      .pkt_valid(pkt_valid), .pkt_crc_err(pkt_crc_err), .pkt_abort(pkt_abort), .busy(busy)
`ifdef PPI_RX_TIMESTAMP_EN
      , .ts_day(ts_day), .ts_hour(ts_hour), .ts_min(ts_min),
      .ts_sec(ts_sec), .ts_ms(ts_ms), .ts_us(ts_us)
`endif
   );

   always @(negedge clk) begin
      if (pkt_valid)   n_valid++;
      if (pkt_crc_err) n_crc++;
      if (pkt_abort)   n_abort++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w);
      @(posedge clk); #1;
      data_ppi = w;
      clk_ppi  = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      clk_ppi = 1'b0;
      @(posedge clk);
   endtask

   task automatic send_range(input int unsigned lo, input int unsigned hi);
      for (int unsigned i = lo; i <= hi; i++) send_word(pkt[i]);
   endtask

   task automatic fs_pulse;
      @(posedge clk); #1 fs = 1'b1;
      repeat (2) @(posedge clk);
      #1 fs = 1'b0;
   endtask

   task automatic build(input logic [15:0] cmd, input logic [15:0] sub);
      logic [15:0] x;
      pkt[0] = 16'hFFFF;
      pkt[1] = cmd;
      pkt[2] = sub;
      pkt[3] = 16'd0;
      for (int unsigned i = 4; i <= 7; i++) pkt[i] = 16'd1;
      pkt[8] = 16'd50;
      for (int unsigned i = 9; i <= 254; i++) pkt[i] = 16'(i);
      x = 16'hFFFF;
      for (int unsigned i = 1; i <= 254; i++) x = x ^ pkt[i];
      pkt[255] = x;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
      @(posedge clk); #1 rd_addr = a;
      @(posedge clk); #1;
      chk(tag, rd_data, exp);
   endtask

   initial begin
      int unsigned edges;
      logic        seen;

      // reset state, sampled while rst_n is still low
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_valid", pkt_valid, 0);
      chk("rst_crc_err", pkt_crc_err, 0);
      chk("rst_abort", pkt_abort, 0);
      chk("rst_cmd", pkt_cmd, 0);
      chk("rst_sub", pkt_sub, 0);
      chk("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      tick(2);

      // good DDS packet, with FS-to-busy and last-word-to-valid timing
      build(16'hFFF1, 16'hFFD1);
      @(posedge clk); #1 fs = 1'b1;
      @(posedge clk); #1 chk("fs_busy_early", busy, 0);
      @(posedge clk); #1 chk("fs_busy", busy, 1);
      fs = 1'b0;
      send_range(0, 254);
      @(posedge clk); #1;
      data_ppi = pkt[255];
      clk_ppi  = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("last_valid_early", pkt_valid, 0);
      chk("last_busy_check", busy, 1);
      clk_ppi = 1'b0;
      @(posedge clk); #1;
      chk("good_valid", pkt_valid, 1);
      chk("good_cmd", pkt_cmd, 16'hFFF1);
      chk("good_sub", pkt_sub, 16'hFFD1);
      chk("good_busy_idle", busy, 0);
`ifdef PPI_RX_TIMESTAMP_EN
      chk("good_ts_us", ts_us, 16'd50);
      chk("good_ts_day", ts_day, 16'd0);
`endif
      @(posedge clk); #1 chk("good_valid_pulse", pkt_valid, 0);
      tick(3);
      chk("good_n_valid", n_valid, 1);
      chk("good_n_crc", n_crc, 0);
      rd_chk("rd_100", 8'd100, 16'd100);
      rd_chk("rd_1", 8'd1, 16'hFFF1);
      rd_chk("rd_255", 8'd255, pkt[255]);

      // corrupt word 100: checksum no longer matches
      build(16'hFFF0, 16'hFFD1);
      pkt[100] = 16'h0000;
      fs_pulse();
      send_range(0, 255);
      tick(4);
      chk("bad_n_crc", n_crc, 1);
      chk("bad_n_valid", n_valid, 1);
      chk("bad_cmd_kept", pkt_cmd, 16'hFFF1);

      // preamble repeat: three start words before the command
      build(16'hFFF0, 16'h1234);
      fs_pulse();
      send_word(16'hFFFF);
      send_word(16'hFFFF);
      send_range(0, 255);
      tick(4);
      chk("pre_n_valid", n_valid, 2);
      chk("pre_cmd", pkt_cmd, 16'hFFF0);
      chk("pre_sub", pkt_sub, 16'h1234);
      rd_chk("pre_buf1", 8'd1, 16'hFFF0);
      rd_chk("pre_buf2", 8'd2, 16'h1234);

      // timeout: strobe stops after word 50; registered 1 edge, processed 1 edge, then 64 idle
      build(16'hFFF1, 16'hFFD1);
      fs_pulse();
      send_range(0, 49);
      @(posedge clk); #1;
      data_ppi = pkt[50];
      clk_ppi  = 1'b1;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 200) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 2) clk_ppi = 1'b0;
         if (pkt_abort) seen = 1'b1;
      end
      chk("timeout_latency", edges, 66);
      @(posedge clk); #1;
      chk("timeout_busy", busy, 0);
      chk("timeout_abort_pulse", pkt_abort, 0);
      tick(2);
      chk("timeout_n_abort", n_abort, 1);
      chk("timeout_n_valid", n_valid, 2);

      // restart: FS arrives during word 120, then a full packet follows
      fs_pulse();
      send_range(0, 119);
      @(posedge clk); #1;
      data_ppi = pkt[120];
      clk_ppi  = 1'b1;
      @(posedge clk); #1 fs = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      clk_ppi = 1'b0;
      fs      = 1'b0;
      tick(3);
      chk("restart_n_abort", n_abort, 2);
      chk("restart_busy", busy, 1);
      send_range(0, 255);
      tick(4);
      chk("restart_n_valid", n_valid, 3);
      chk("restart_cmd", pkt_cmd, 16'hFFF1);

      // reset mid-packet: silent discard, then a normal packet
      fs_pulse();
      send_range(0, 80);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmd", pkt_cmd, 0);
      chk("mid_rst_sub", pkt_sub, 0);
      chk("mid_rst_abort", pkt_abort, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      tick(10);
      chk("mid_rst_n_abort", n_abort, 2);
      fs_pulse();
      send_range(0, 255);
      tick(4);
      chk("post_rst_n_valid", n_valid, 4);
      chk("post_rst_cmd", pkt_cmd, 16'hFFF1);
      chk("post_rst_n_crc", n_crc, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
